// File: rtl/xpsr_ctrl.sv
// xpsr_ctrl: fixed-priority write arbiter and sequencer for the xPSR register file.
// Sources: exception entry > exception return > MSR > IT load > ALU flags.
// Optional feature macro: XPSR_CTRL_PREEMPT_EN (exception entry aborts a pending return).
module xpsr_ctrl #(
  parameter int unsigned RET_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        entry_req,
  input  logic [8:0]  exc_num,
  input  logic        ret_req,
  input  logic        pop_valid,
  input  logic [31:0] pop_data,
  input  logic        msr_req,
  input  logic [31:0] msr_data,
  input  logic        it_req,
  input  logic [7:0]  it_bits,
  input  logic        alu_req,
  input  logic [4:0]  alu_flags,
  input  logic [4:0]  alu_mask,
  output logic [31:0] set_data,
  output logic [4:0]  en_apsr,
  output logic        en_ipsr,
  output logic        en_epsr,
  output logic        entry_ack,
  output logic        ret_ack,
  output logic        msr_ack,
  output logic        it_ack,
  output logic        alu_ack,
  output logic        entry_done,
  output logic        ret_done,
  output logic        ret_err,
  output logic        ret_abort,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(RET_TIMEOUT + 1);
  localparam logic [31:0] EPSR_T_ONLY = 32'h0100_0000;

  typedef enum logic [1:0] {IDLE, ENT_IPSR, ENT_EPSR, RET_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Only the NZCVQ field of the MSR source reaches the register.
  logic unused_msr;
  assign unused_msr = ^msr_data[26:0];

  // Arbitration, sequencing and registered write/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      set_data   <= '0;
      en_apsr    <= '0;
      en_ipsr    <= 1'b0;
      en_epsr    <= 1'b0;
      entry_ack  <= 1'b0;
      ret_ack    <= 1'b0;
      msr_ack    <= 1'b0;
      it_ack     <= 1'b0;
      alu_ack    <= 1'b0;
      entry_done <= 1'b0;
      ret_done   <= 1'b0;
      ret_err    <= 1'b0;
      ret_abort  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      set_data   <= '0;
      en_apsr    <= '0;
      en_ipsr    <= 1'b0;
      en_epsr    <= 1'b0;
      entry_ack  <= 1'b0;
      ret_ack    <= 1'b0;
      msr_ack    <= 1'b0;
      it_ack     <= 1'b0;
      alu_ack    <= 1'b0;
      entry_done <= 1'b0;
      ret_done   <= 1'b0;
      ret_err    <= 1'b0;
      ret_abort  <= 1'b0;
      busy       <= 1'b0;
      case (state)
        // ENT_EPSR is the last entry cycle, so it arbitrates like IDLE.
        IDLE, ENT_EPSR: begin
          state <= IDLE;
          if (entry_req && !entry_ack) begin
            state     <= ENT_IPSR;
            busy      <= 1'b1;
            set_data  <= {23'd0, exc_num};
            en_ipsr   <= 1'b1;
            entry_ack <= 1'b1;
          end else if (ret_req && !ret_ack) begin
            state   <= RET_WAIT;
            busy    <= 1'b1;
            cnt     <= '0;
            ret_ack <= 1'b1;
          end else if (msr_req && !msr_ack) begin
            set_data <= {msr_data[31:27], 27'd0};
            en_apsr  <= 5'b11111;
            msr_ack  <= 1'b1;
          end else if (it_req && !it_ack) begin
            set_data <= {5'd0, it_bits[1:0], 1'b1, 8'd0, it_bits[7:2], 10'd0};
            en_epsr  <= 1'b1;
            it_ack   <= 1'b1;
          end else if (alu_req && !alu_ack) begin
            set_data <= {alu_flags, 27'd0};
            en_apsr  <= alu_mask;
            alu_ack  <= 1'b1;
          end
        end
        // Second entry cycle: set T, clear IT/ICI.
        ENT_IPSR: begin
          state      <= ENT_EPSR;
          busy       <= 1'b1;
          set_data   <= EPSR_T_ONLY;
          en_epsr    <= 1'b1;
          entry_done <= 1'b1;
        end
        RET_WAIT: begin
          busy <= 1'b1;
`ifdef XPSR_CTRL_PREEMPT_EN
          if (entry_req) begin
            state     <= ENT_IPSR;
            ret_abort <= 1'b1;
            set_data  <= {23'd0, exc_num};
            en_ipsr   <= 1'b1;
            entry_ack <= 1'b1;
          end else
`endif
          if (pop_valid) begin
            state    <= IDLE;
            busy     <= 1'b0;
            set_data <= pop_data;
            en_apsr  <= 5'b11111;
            en_ipsr  <= 1'b1;
            en_epsr  <= 1'b1;
            ret_done <= 1'b1;
          end else if (cnt == CNT_W'(RET_TIMEOUT - 1)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ret_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xpsr_ctrl.sv
// Directed self-checking bench for xpsr_ctrl (default RET_TIMEOUT = 16).
// Honours XPSR_CTRL_PREEMPT_EN when the same macro is defined for the build.
module tb_xpsr_ctrl;

  logic        clk;
  logic        rst_n;
  logic        entry_req;
  logic [8:0]  exc_num;
  logic        ret_req;
  logic        pop_valid;
  logic [31:0] pop_data;
  logic        msr_req;
  logic [31:0] msr_data;
  logic        it_req;
  logic [7:0]  it_bits;
  logic        alu_req;
  logic [4:0]  alu_flags;
  logic [4:0]  alu_mask;
  logic [31:0] set_data;
  logic [4:0]  en_apsr;
  logic        en_ipsr;
  logic        en_epsr;
  logic        entry_ack;
  logic        ret_ack;
  logic        msr_ack;
  logic        it_ack;
  logic        alu_ack;
  logic        entry_done;
  logic        ret_done;
  logic        ret_err;
  logic        ret_abort;
  logic        busy;

  int checks;
  int failures;

  xpsr_ctrl #(.RET_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .entry_req(entry_req), .exc_num(exc_num),
    .ret_req(ret_req), .pop_valid(pop_valid), .pop_data(pop_data),
    .msr_req(msr_req), .msr_data(msr_data),
    .it_req(it_req), .it_bits(it_bits),
    .alu_req(alu_req), .alu_flags(alu_flags), .alu_mask(alu_mask),
    .set_data(set_data), .en_apsr(en_apsr), .en_ipsr(en_ipsr), .en_epsr(en_epsr),
    .entry_ack(entry_ack), .ret_ack(ret_ack), .msr_ack(msr_ack),
    .it_ack(it_ack), .alu_ack(alu_ack),
    .entry_done(entry_done), .ret_done(ret_done), .ret_err(ret_err),
    .ret_abort(ret_abort), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    entry_req = 0; exc_num = '0; ret_req = 0; pop_valid = 0; pop_data = '0;
    msr_req = 0; msr_data = '0; it_req = 0; it_bits = '0;
    alu_req = 0; alu_flags = '0; alu_mask = '0;
    step(); step();
    checks++; if (set_data !== 32'h0) begin failures++; $display("FAIL reset_set_data got %h exp %h", set_data, 32'h0); end
    checks++; if ({en_apsr, en_ipsr, en_epsr} !== 7'h0) begin failures++; $display("FAIL reset_enables got %b exp 0", {en_apsr, en_ipsr, en_epsr}); end
    checks++; if ({entry_ack, ret_ack, msr_ack, it_ack, alu_ack, entry_done, ret_done, ret_err, ret_abort, busy} !== 10'h0) begin
      failures++; $display("FAIL reset_pulses got %b exp 0", {entry_ack, ret_ack, msr_ack, it_ack, alu_ack, entry_done, ret_done, ret_err, ret_abort, busy}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu();
    alu_req = 1; alu_flags = 5'b10100; alu_mask = 5'b11000;
    step();
    alu_req = 0;
    checks++; if (set_data !== 32'hA000_0000) begin failures++; $display("FAIL alu_set_data got %h exp %h", set_data, 32'hA000_0000); end
    checks++; if (en_apsr !== 5'b11000) begin failures++; $display("FAIL alu_en_apsr got %b exp %b", en_apsr, 5'b11000); end
    checks++; if (alu_ack !== 1'b1) begin failures++; $display("FAIL alu_ack got %b exp 1", alu_ack); end
    step();
    checks++; if ({set_data, en_apsr, alu_ack} !== 38'h0) begin failures++; $display("FAIL alu_idle got %h/%b/%b exp 0", set_data, en_apsr, alu_ack); end
    // Zero mask: acked, no enables.
    alu_req = 1; alu_flags = 5'b11111; alu_mask = 5'b00000;
    step();
    alu_req = 0;
    checks++; if ({alu_ack, en_apsr} !== 6'b1_00000) begin failures++; $display("FAIL alu_mask0 got ack %b en %b exp ack 1 en 0", alu_ack, en_apsr); end
    step();
  endtask

  task automatic test_alu_held();
    logic [3:0] pat;
    alu_req = 1; alu_flags = 5'b00110; alu_mask = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      step();
      pat[3-i] = alu_ack;
    end
    alu_req = 0;
    checks++; if (pat !== 4'b1010) begin failures++; $display("FAIL alu_held_pattern got %b exp %b", pat, 4'b1010); end
    step();
  endtask

  task automatic test_priority();
    entry_req = 1; exc_num = 9'd15; msr_req = 1; msr_data = 32'hDEAD_BEEF;
    alu_req = 1; alu_flags = 5'b00001; alu_mask = 5'b00001;
    step();
    entry_req = 0;
    checks++; if ({set_data, en_ipsr, entry_ack, busy, en_epsr, msr_ack} !== {32'd15, 5'b11100}) begin
      failures++; $display("FAIL prio_ipsr got %h ipsr %b ack %b busy %b exp 0000000f 1 1 1", set_data, en_ipsr, entry_ack, busy); end
    step();
    checks++; if ({set_data, en_epsr, entry_done, en_ipsr, en_apsr} !== {32'h0100_0000, 2'b11, 6'b0}) begin
      failures++; $display("FAIL prio_epsr got %h epsr %b done %b exp 01000000 1 1", set_data, en_epsr, entry_done); end
    step();
    msr_req = 0;
    checks++; if ({set_data, en_apsr, msr_ack, alu_ack} !== {32'hD800_0000, 5'b11111, 2'b10}) begin
      failures++; $display("FAIL prio_msr got %h en %b ack %b exp d8000000 11111 1", set_data, en_apsr, msr_ack); end
    step();
    alu_req = 0;
    checks++; if ({set_data, en_apsr, alu_ack} !== {32'h0800_0000, 5'b00001, 1'b1}) begin
      failures++; $display("FAIL prio_alu got %h en %b ack %b exp 08000000 00001 1", set_data, en_apsr, alu_ack); end
    step();
  endtask

  task automatic test_it();
    it_req = 1; it_bits = 8'hA6;
    step();
    it_req = 0;
    checks++; if ({set_data, en_epsr, it_ack, en_apsr, en_ipsr} !== {32'h0500_A400, 2'b11, 6'b0}) begin
      failures++; $display("FAIL it_write got %h epsr %b ack %b exp 0500a400 1 1", set_data, en_epsr, it_ack); end
    step();
  endtask

  task automatic test_ret_ok();
    ret_req = 1;
    step();
    ret_req = 0;
    checks++; if ({ret_ack, busy, en_apsr, en_ipsr, en_epsr} !== {2'b11, 7'b0}) begin
      failures++; $display("FAIL ret_ack got ack %b busy %b exp 1 1", ret_ack, busy); end
    step(); step();
    pop_valid = 1; pop_data = 32'hF100_0003;
    step();
    pop_valid = 0;
    checks++; if ({set_data, en_apsr, en_ipsr, en_epsr, ret_done} !== {32'hF100_0003, 8'hFF}) begin
      failures++; $display("FAIL ret_write got %h en %b%b%b done %b exp f1000003 all 1", set_data, en_apsr, en_ipsr, en_epsr, ret_done); end
    step();
    checks++; if ({busy, ret_done, en_apsr} !== 7'b0) begin failures++; $display("FAIL ret_after got busy %b done %b exp 0 0", busy, ret_done); end
  endtask

  task automatic test_ret_timeout();
    int  n;
    bit  seen;
    bit  wrote;
    ret_req = 1;
    step();
    ret_req = 0;
    n = 0; seen = 0; wrote = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      step();
      if (en_apsr != 0 || en_ipsr || en_epsr) wrote = 1;
      if (ret_err) begin seen = 1; n = i; end
    end
    checks++; if (seen !== 1'b1 || n != 16) begin failures++; $display("FAIL ret_timeout got seen %b after %0d exp 1 after 16", seen, n); end
    checks++; if (wrote !== 1'b0) begin failures++; $display("FAIL ret_timeout_write got %b exp 0", wrote); end
    checks++; if ({busy, ret_done} !== 2'b0) begin failures++; $display("FAIL ret_timeout_busy got %b exp 0", busy); end
    step();
    checks++; if (ret_err !== 1'b0) begin failures++; $display("FAIL ret_err_pulse got %b exp 0", ret_err); end
  endtask

  task automatic test_entry_during_ret();
    ret_req = 1;
    step();
    ret_req = 0;
    entry_req = 1; exc_num = 9'd3;
    step();
`ifdef XPSR_CTRL_PREEMPT_EN
    checks++; if ({ret_abort, entry_ack, en_ipsr, set_data} !== {3'b111, 32'd3}) begin
      failures++; $display("FAIL preempt_abort got abort %b ack %b data %h exp 1 1 3", ret_abort, entry_ack, set_data); end
    entry_req = 0;
    step();
    checks++; if ({entry_done, ret_done} !== 2'b10) begin failures++; $display("FAIL preempt_done got %b exp 10", {entry_done, ret_done}); end
    step();
`else
    checks++; if ({entry_ack, ret_abort, en_ipsr} !== 3'b0) begin failures++; $display("FAIL noabort_wait got %b exp 0", {entry_ack, ret_abort, en_ipsr}); end
    pop_valid = 1; pop_data = 32'h0100_0010;
    step();
    pop_valid = 0;
    checks++; if ({ret_done, entry_ack, ret_abort} !== 3'b100) begin failures++; $display("FAIL noabort_retdone got %b exp 100", {ret_done, entry_ack, ret_abort}); end
    step();
    entry_req = 0;
    checks++; if ({entry_ack, en_ipsr, set_data} !== {2'b11, 32'd3}) begin
      failures++; $display("FAIL noabort_entry got ack %b ipsr %b data %h exp 1 1 3", entry_ack, en_ipsr, set_data); end
    step();
    step();
`endif
  endtask

  task automatic test_reset_abort();
    entry_req = 1; exc_num = 9'd7;
    step();
    entry_req = 0;
    rst_n = 0;
    #1;
    checks++; if ({entry_ack, en_ipsr, busy, set_data} !== 35'h0) begin
      failures++; $display("FAIL rst_abort_now got ack %b ipsr %b busy %b data %h exp 0", entry_ack, en_ipsr, busy, set_data); end
    #2;
    rst_n = 1;
    step();
    checks++; if ({entry_done, en_epsr, busy, set_data} !== 35'h0) begin
      failures++; $display("FAIL rst_abort_after got done %b epsr %b busy %b data %h exp 0", entry_done, en_epsr, busy, set_data); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_alu();
    test_alu_held();
    test_priority();
    test_it();
    test_ret_ok();
    test_ret_timeout();
    test_entry_during_ret();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
